vx_gbar_arbiter: RTL and testbench
==================================

# vx_gbar_arbiter

Global barrier controller shared by all cores of a cluster. Each core's warp scheduler raises a global-barrier request once all of its active warps have arrived at barrier `id`. This block arbitrates those requests, one per cycle, and tracks per-barrier core arrival masks. When a barrier's expected core count is reached, it broadcasts a single-cycle release response to every core. It sits at cluster level, between the per-core gbar bus masters and their shared response wire.

## Interface
Parameters:
- `NUM_REQS`, default `NUM_CORES`: number of requesting cores.
- `NUM_BARRIERS`, default `NUM_BARRIERS`: barrier ids tracked; `NB_WIDTH = LOG2UP(NUM_BARRIERS)`.
- `NC_WIDTH`, default `LOG2UP(NUM_REQS)`: width of core id and size fields.

Ports:
- `clk` — in, 1 — clock.
- `reset` — in, 1 — synchronous, active-high reset.
- `req_valid` — in, `NUM_REQS` — per-core request valid.
- `req_id` — in, `NUM_REQS`×`NB_WIDTH` — barrier id.
- `req_size_m1` — in, `NUM_REQS`×`NC_WIDTH` — expected participating cores minus 1.
- `req_core_id` — in, `NUM_REQS`×`NC_WIDTH` — sender core id; selects the arrival-mask bit.
- `req_ready` — out, `NUM_REQS` — one-hot grant; at most one bit set per cycle.
- `rsp_valid` — out, 1 — barrier release pulse, broadcast to all cores.
- `rsp_id` — out, `NB_WIDTH` — released barrier id.

## Operation
- State per barrier b:
  - `arr_mask[b]` (`NUM_REQS` bits).
  - `size_m1[b]` (`NC_WIDTH` bits), latched on the first arrival of an epoch.
  - `busy[b]`, set while the mask is non-zero.
- Arbitration:
  - Round-robin over `req_valid`.
  - `req_ready[g]=1` only for the granted index g.
  - The handshake is `req_valid[g] && req_ready[g]`.
  - After a grant, the priority pointer moves to g+1 (mod `NUM_REQS`). With no request, the pointer holds.
- On an accepted request (id, core, sz):
  - If `busy[id]==0`: set `size_m1[id]=sz`.
  - Compute `mask_n = arr_mask[id] | (1<<core)`.
  - If popcount(`mask_n`) == `size_m1_eff+1`, the barrier completes:
    - `arr_mask[id]` is cleared and `busy[id]` is cleared.
    - Next cycle: `rsp_valid=1`, `rsp_id=id`.
  - Otherwise `arr_mask[id]=mask_n` and `busy[id]=1`.
  - `size_m1_eff` is `sz` on first arrival, else the latched `size_m1[id]`.
  - popcount is computed at width `NC_WIDTH+1`, so `size_m1=NUM_REQS-1` does not overflow.
- Duplicate arrival (core bit already set):
  - Mask unchanged, no completion.
  - Flag with a runtime assert in non-NDEBUG builds.
- Size mismatch (`sz != size_m1[id]` on a non-first arrival): the latched value wins; runtime assert.
- Single-core barrier (`size_m1=0`): completes on its own arrival and never sets `busy`.
- Different barrier ids progress independently; only one arrival is processed per cycle, so per-id updates never collide.

## Timing
- Grant: combinational from `req_valid` and the registered pointer. Requesters must hold their request fields stable until the handshake.
- Release latency: `rsp_valid` is asserted exactly 1 cycle after the completing handshake and lasts exactly 1 cycle.
- Back-to-back completions (ids A then B on consecutive cycles) give consecutive `rsp_valid` pulses with `rsp_id` A, then B.
- A new arrival at id X in the cycle right after X completed starts a fresh epoch: the mask starts from zero and the size is re-latched.
- Reset values:
  - `req_ready` = 0 during reset.
  - `rsp_valid` = 0, `rsp_id` = 0.
  - All `arr_mask`, `busy` and `size_m1` = 0.
  - Priority pointer = 0.
- Reset mid-operation: all partial arrivals are discarded and no release is emitted. Cores are reset in the same domain, so they re-issue their requests.
- Response is not backpressured; cores sample `rsp_valid` every cycle.

## Structure
- `VX_gpu_pkg` holds the shared request/response struct: `gbar_req_t` {id, size_m1, core_id}. The `VX_gbar_bus_if` field widths are derived from `NB_WIDTH` and `NC_WIDTH`.
- One sub-module: the codebase round-robin arbiter `VX_rr_arbiter` (`NUM_REQS`, one-hot grant, index output, `unlock` tied to the handshake).
- Popcount uses the existing `POP_COUNT` macro. The response is registered directly, with no elastic buffer.

## Test plan
- Round-robin fairness: `NUM_REQS=4`, with cores 0–3 requesting simultaneously on distinct ids with `size_m1=1`:
  - Grants go 0,1,2,3 on four consecutive cycles.
  - No `rsp_valid` at any point.
- Basic completion: cores 2 then 0 each send id 1 with `size_m1=1`, arrivals at cycles 5 and 9:
  - `rsp_valid=1`, `rsp_id=1` at cycle 10 only.
  - `arr_mask[1]=0` afterwards.
- Single-core barrier: core 3 sends id 0 with `size_m1=0` at cycle 4:
  - `rsp_valid` at cycle 5.
  - `busy[0]` never set.
- Duplicate arrival: core 1 arrives twice on id 2 with `size_m1=1`:
  - No release, and the assert fires.
  - A subsequent arrival from core 0 releases id 2 one cycle later.
- Interleaved ids and re-arm:
  - Ids 0 and 3 complete on consecutive cycles, giving two pulses with `rsp_id` 0, then 3.
  - Core 0 arrives at id 0 in the cycle after id 0's release; a fresh epoch is latched.
- Reset mid-barrier: reset is asserted after 2 of 4 arrivals on id 1:
  - After reset, all masks are 0 and `rsp_valid=0`.
  - Four new arrivals then release id 1 exactly once.

Source files
------------

// File: rtl/vx_gbar_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// vx_gbar_arbiter_pkg
// Shared constants and helpers for the cluster-level global barrier block.
//   GBAR_NUM_CORES / GBAR_NUM_BARRIERS : default cluster configuration
//   log2up()                           : width helper, never returns 0
//   gbar_req_t                         : one core's barrier request
//                                        {id, size_m1, core_id} at the
//                                        default widths
// ----------------------------------------------------------------------------
package vx_gbar_arbiter_pkg;

    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_NUM_BARRIERS = 4;

    // A 1-entry field still needs one bit, so clamp at 1.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GBAR_NB_WIDTH = log2up(GBAR_NUM_BARRIERS);
    localparam int GBAR_NC_WIDTH = log2up(GBAR_NUM_CORES);

    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
        logic [GBAR_NC_WIDTH-1:0] size_m1;
        logic [GBAR_NC_WIDTH-1:0] core_id;
    } gbar_req_t;

endpackage

// File: rtl/vx_gbar_arbiter_if.sv
// ----------------------------------------------------------------------------
// vx_gbar_arbiter_if
// Global-barrier bus between the per-core warp schedulers (master) and the
// cluster barrier controller (slave).
//   req_valid   [NUM_REQS]           : per-core request valid
//   req_id      [NUM_REQS][NB_WIDTH] : barrier id
//   req_size_m1 [NUM_REQS][NC_WIDTH] : participating cores minus one
//   req_core_id [NUM_REQS][NC_WIDTH] : sender core id (arrival-mask bit)
//   req_ready   [NUM_REQS]           : one-hot grant
//   rsp_valid / rsp_id               : single-cycle release broadcast
// ----------------------------------------------------------------------------
interface vx_gbar_arbiter_if
    import vx_gbar_arbiter_pkg::*;
#(
    parameter int NUM_REQS = GBAR_NUM_CORES,
    parameter int NB_WIDTH = GBAR_NB_WIDTH,
    parameter int NC_WIDTH = log2up(NUM_REQS)
);

    logic [NUM_REQS-1:0]               req_valid;
    logic [NUM_REQS-1:0][NB_WIDTH-1:0] req_id;
    logic [NUM_REQS-1:0][NC_WIDTH-1:0] req_size_m1;
    logic [NUM_REQS-1:0][NC_WIDTH-1:0] req_core_id;
    logic [NUM_REQS-1:0]               req_ready;
    logic                              rsp_valid;
    logic [NB_WIDTH-1:0]               rsp_id;

    modport master (
        output req_valid, req_id, req_size_m1, req_core_id,
        input  req_ready, rsp_valid, rsp_id
    );

    modport slave (
        input  req_valid, req_id, req_size_m1, req_core_id,
        output req_ready, rsp_valid, rsp_id
    );

endinterface

// File: rtl/vx_gbar_arbiter_rr.sv
// ----------------------------------------------------------------------------
// vx_gbar_arbiter_rr
// Round-robin arbiter with a registered priority pointer.
//   clk, reset      : clock, synchronous active-high reset
//   i_requests      : request vector
//   i_unlock        : grant was consumed this cycle; advance the pointer
//   o_grant_onehot  : one-hot grant (all zero during reset)
//   o_grant_idx     : index of the granted requester
//   o_grant_valid   : some requester is granted
// The grant is combinational from i_requests and the pointer; the pointer
// moves to the slot after the winner only when the grant is consumed.
// ----------------------------------------------------------------------------
module vx_gbar_arbiter_rr
    import vx_gbar_arbiter_pkg::*;
#(
    parameter int NUM_REQS  = GBAR_NUM_CORES,
    parameter int IDX_WIDTH = log2up(NUM_REQS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQS-1:0]  i_requests,
    input  logic                 i_unlock,
    output logic [NUM_REQS-1:0]  o_grant_onehot,
    output logic [IDX_WIDTH-1:0] o_grant_idx,
    output logic                 o_grant_valid
);

    logic [IDX_WIDTH-1:0] r_ptr;
    logic [IDX_WIDTH-1:0] w_idx;
    logic                 w_found;
    int                   w_k;

    // Scan from the pointer, wrapping once; first active request wins.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= NUM_REQS) begin
                w_k = w_k - NUM_REQS;
            end
            if (!w_found && i_requests[w_k]) begin
                w_found = 1'b1;
                w_idx   = IDX_WIDTH'(w_k);
            end
        end
    end

    assign o_grant_valid  = w_found && !reset;
    assign o_grant_idx    = w_idx;
    assign o_grant_onehot = o_grant_valid ? (NUM_REQS'(1) << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_unlock && o_grant_valid) begin
            r_ptr <= (int'(w_idx) == NUM_REQS - 1) ? '0 : w_idx + IDX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/vx_gbar_arbiter.sv
// ----------------------------------------------------------------------------
// vx_gbar_arbiter
// Cluster global barrier controller. Accepts at most one core arrival per
// cycle (round-robin), accumulates per-barrier arrival masks and broadcasts
// a one-cycle release when the expected core count is reached.
//   clk, reset : clock, synchronous active-high reset
//   bus        : vx_gbar_arbiter_if.slave (requests in, grant and release out)
// Per barrier: arrival mask, latched size_m1, busy (mask non-zero).
// ----------------------------------------------------------------------------
module vx_gbar_arbiter
    import vx_gbar_arbiter_pkg::*;
#(
    parameter int NUM_REQS     = GBAR_NUM_CORES,
    parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
    parameter int NB_WIDTH     = log2up(NUM_BARRIERS),
    parameter int NC_WIDTH     = log2up(NUM_REQS)
) (
    input  logic              clk,
    input  logic              reset,
    vx_gbar_arbiter_if.slave  bus
);

    localparam int CI_WIDTH = log2up(NUM_REQS);
    // One extra bit so a full cluster (size_m1 = NUM_REQS-1) compares cleanly.
    localparam int PC_WIDTH = NC_WIDTH + 1;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic [NC_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] core_id;
    } req_t;

    // Per-barrier state.
    logic [NUM_REQS-1:0] r_arr_mask [NUM_BARRIERS];
    logic [NC_WIDTH-1:0] r_size_m1  [NUM_BARRIERS];
    logic                r_busy     [NUM_BARRIERS];

    logic                r_rsp_valid;
    logic [NB_WIDTH-1:0] r_rsp_id;

    req_t                w_reqs [NUM_REQS];
    req_t                w_sel;
    logic [NUM_REQS-1:0] w_grant_onehot;
    logic [CI_WIDTH-1:0] w_grant_idx;
    logic                w_grant_valid;
    logic                w_fire;
    logic                w_first;
    logic [NC_WIDTH-1:0] w_sz_eff;
    logic [NUM_REQS-1:0] w_mask_cur;
    logic [NUM_REQS-1:0] w_core_bit;
    logic [NUM_REQS-1:0] w_mask_n;
    logic                w_dup;
    logic [PC_WIDTH-1:0] w_pop;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_done;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
            assign w_reqs[gi] = '{id:      bus.req_id[gi],
                                  size_m1: bus.req_size_m1[gi],
                                  core_id: bus.req_core_id[gi]};
        end
    endgenerate

    vx_gbar_arbiter_rr #(
        .NUM_REQS  (NUM_REQS),
        .IDX_WIDTH (CI_WIDTH)
    ) u_rr (
        .clk            (clk),
        .reset          (reset),
        .i_requests     (bus.req_valid),
        .i_unlock       (w_fire),
        .o_grant_onehot (w_grant_onehot),
        .o_grant_idx    (w_grant_idx),
        .o_grant_valid  (w_grant_valid)
    );

    // A grant is only ever given to a valid requester, so grant == handshake.
    assign bus.req_ready = w_grant_onehot;
    assign w_fire        = w_grant_valid;
    assign w_sel         = w_reqs[w_grant_idx];

    assign w_first    = !r_busy[w_sel.id];
    assign w_sz_eff   = w_first ? w_sel.size_m1 : r_size_m1[w_sel.id];
    assign w_mask_cur = r_arr_mask[w_sel.id];
    assign w_core_bit = NUM_REQS'(1) << w_sel.core_id;
    assign w_mask_n   = w_mask_cur | w_core_bit;
    assign w_dup      = |(w_mask_cur & w_core_bit);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_pop = w_pop + PC_WIDTH'(w_mask_n[i]);
        end
    end

    assign w_target = {1'b0, w_sz_eff} + PC_WIDTH'(1);
    assign w_done   = w_fire && !w_dup && (w_pop == w_target);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_arr_mask[b] <= '0;
                r_size_m1[b]  <= '0;
                r_busy[b]     <= 1'b0;
            end
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_id <= w_sel.id;
            end
            if (w_fire) begin
                // First arrival of an epoch latches the expected size.
                if (w_first) begin
                    r_size_m1[w_sel.id] <= w_sel.size_m1;
                end
                if (w_done) begin
                    r_arr_mask[w_sel.id] <= '0;
                    r_busy[w_sel.id]     <= 1'b0;
                end else begin
                    r_arr_mask[w_sel.id] <= w_mask_n;
                    r_busy[w_sel.id]     <= 1'b1;
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;

`ifndef NDEBUG
    // Protocol checks on the requesters; the hardware tolerates both cases
    // (duplicate is ignored, latched size wins), so they only warn.
    always_ff @(posedge clk) begin
        if (!reset && w_fire) begin
            assert (!w_dup)
                else $warning("gbar: duplicate arrival id=%0d core=%0d", w_sel.id, w_sel.core_id);
            assert (w_first || (w_sel.size_m1 == r_size_m1[w_sel.id]))
                else $warning("gbar: size_m1 differs from latched value id=%0d", w_sel.id);
        end
    end
`endif

endmodule

// File: tb/tb_vx_gbar_arbiter.sv
module tb_vx_gbar_arbiter;

    localparam int NR = 4;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vx_gbar_arbiter_if #(.NUM_REQS(NR), .NB_WIDTH(2), .NC_WIDTH(2)) bus ();

    vx_gbar_arbiter #(
        .NUM_REQS     (NR),
        .NUM_BARRIERS (NB),
        .NB_WIDTH     (2),
        .NC_WIDTH     (2)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Pending request held by each core until its handshake.
    bit pend_v    [NR];
    int pend_id   [NR];
    int pend_sz   [NR];
    int pend_core [NR];

    // Reference model: which cores have arrived, how many are needed.
    bit arrived [NB][NR];
    int target  [NB];
    bit active  [NB];
    int ptr;
    int last_grant;
    int exp_pulses [NB];
    int obs_pulses [NB];
    int rand_sz    [NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
            end
    endtask

    function automatic bit any_pend();
        for (int c = 0; c < NR; c++) if (pend_v[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_grant();
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (ptr + i) % NR;
            if (pend_v[k]) return k;
        end
        return -1;
    endfunction

    // Returns 1 when this arrival releases barrier b.
    function automatic bit model_arrive(input int b, input int c, input int sz);
        int n;
        if (!active[b]) begin
            target[b] = sz + 1;
            active[b] = 1'b1;
        end
        if (arrived[b][c]) return 1'b0;
        arrived[b][c] = 1'b1;
        n = 0;
        for (int k = 0; k < NR; k++) n += int'(arrived[b][k]);
        if (n == target[b]) begin
            for (int k = 0; k < NR; k++) arrived[b][k] = 1'b0;
            active[b] = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            active[b] = 1'b0;
            target[b] = 0;
            for (int c = 0; c < NR; c++) arrived[b][c] = 1'b0;
        end
        for (int c = 0; c < NR; c++) pend_v[c] = 1'b0;
        ptr = 0;
    endfunction

    function automatic void post(input int c, input int id, input int sz);
        pend_v[c]    = 1'b1;
        pend_id[c]   = id;
        pend_sz[c]   = sz;
        pend_core[c] = c;
    endfunction

    task automatic cycle(input bit do_rst);
        int g;
        bit exp_rsp;
        int exp_id;
        logic [NR-1:0] exp_ready;
        @(negedge clk);
        rst = do_rst;
        for (int c = 0; c < NR; c++) begin
            bus.req_valid[c]   = pend_v[c];
            bus.req_id[c]      = 2'(pend_id[c]);
            bus.req_size_m1[c] = 2'(pend_sz[c]);
            bus.req_core_id[c] = 2'(pend_core[c]);
        end
        #1;
        g = do_rst ? -1 : model_grant();
        exp_ready = (g >= 0) ? (NR'(1) << g) : '0;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        @(posedge clk);
        cyc++;
        exp_rsp    = 1'b0;
        exp_id     = 0;
        last_grant = g;
        if (do_rst) begin
            model_reset();
        end else if (g >= 0) begin
            exp_rsp   = model_arrive(pend_id[g], pend_core[g], pend_sz[g]);
            exp_id    = pend_id[g];
            pend_v[g] = 1'b0;
            ptr       = (g + 1) % NR;
            $display("cycle %0d: grant core=%0d id=%0d size_m1=%0d release=%0d",
                     cyc, g, exp_id, pend_sz[g], exp_rsp);
        end
        #1;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        if (exp_rsp) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
            exp_pulses[exp_id]++;
        end
        if (bus.rsp_valid === 1'b1) obs_pulses[bus.rsp_id]++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (any_pend() && n < budget) begin
            cycle(1'b0);
            n++;
        end
        check("drain_timeout", 32'(any_pend()), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid   = '0;
        bus.req_id      = '0;
        bus.req_size_m1 = '0;
        bus.req_core_id = '0;
        for (int b = 0; b < NB; b++) begin
            exp_pulses[b] = 0;
            obs_pulses[b] = 0;
        end
        model_reset();

        // Reset state, with a request already held during reset.
        post(1, 2, 0);
        cycle(1'b1);
        post(1, 2, 0);
        cycle(1'b1);
        cycle(1'b1);
        check("rsp_id_after_reset", 32'(bus.rsp_id), 32'd0);

        // Round-robin: four simultaneous requests, distinct ids, size 2.
        for (int c = 0; c < NR; c++) post(c, c, 1);
        for (int k = 0; k < NR; k++) begin
            cycle(1'b0);
            check("rr_order", 32'(last_grant), 32'(k));
        end
        idle(2);
        cycle(1'b1);
        cycle(1'b1);

        // Basic completion: cores 2 then 0 on id 1.
        post(2, 1, 1);
        drain(4);
        idle(3);
        post(0, 1, 1);
        drain(4);
        idle(1);
        check("id1_pulses", 32'(obs_pulses[1]), 32'd1);
        // Mask must be empty again: one arrival alone must not release.
        post(0, 1, 1);
        drain(4);
        post(3, 1, 1);
        drain(4);

        // Single-core barrier must not leave id 0 busy.
        post(3, 0, 0);
        drain(4);
        post(1, 0, 1);
        drain(4);
        post(2, 0, 1);
        drain(4);

        // Duplicate arrival on id 2 (expected to warn, no release).
        post(1, 2, 1);
        drain(4);
        post(1, 2, 1);
        drain(4);
        post(0, 2, 1);
        drain(4);

        // Interleaved ids 0 and 3 completing back to back, then re-arm id 0.
        post(0, 0, 1);
        post(1, 3, 1);
        drain(6);
        post(1, 0, 1);
        post(0, 3, 1);
        cycle(1'b0);
        post(2, 0, 0);
        drain(6);
        idle(1);

        // Reset mid-barrier on id 1 (release id 3 first so rsp_id is non-zero).
        post(3, 3, 0);
        drain(4);
        post(0, 1, 3);
        post(1, 1, 3);
        drain(6);
        cycle(1'b1);
        cycle(1'b1);
        check("rsp_id_mid_reset", 32'(bus.rsp_id), 32'd0);
        obs_pulses[1] = 0;
        for (int c = 0; c < NR; c++) post(c, 1, 3);
        drain(10);
        idle(2);
        check("id1_release_once", 32'(obs_pulses[1]), 32'd1);

        // Randomized traffic with a fixed size per id, occasional reset.
        for (int b = 0; b < NB; b++) begin
            rand_sz[b]    = int'($urandom_range(0, 3));
            exp_pulses[b] = 0;
            obs_pulses[b] = 0;
        end
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < NR; c++) begin
                if (!pend_v[c] && ($urandom_range(0, 2) == 0)) begin
                    int id;
                    id = int'($urandom_range(0, NB - 1));
                    if (!arrived[id][c]) post(c, id, rand_sz[id]);
                end
            end
            cycle($urandom_range(0, 149) == 0);
        end
        drain(20);
        idle(2);
        for (int b = 0; b < NB; b++) begin
            check("random_pulses", 32'(obs_pulses[b]), 32'(exp_pulses[b]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
